// File: rtl/mem_stage_master_pkg.sv
// Shared definitions for the MEM-stage memory master: FSM states,
// access size codes and the byte-lane mask helper.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RMW_RD,
    RMW_WR,
    DONE
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Byte enables for an access whose offset has already been naturally aligned
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << offset;
      SZ_H:    lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_master_if.sv
// Pipeline-side request/response and word-memory req/ack bundle for mem_stage_master.
interface mem_stage_master_if #(
  parameter int ADDR_W = 5
);
  logic              ReqValidIn;
  logic              ReadIn;
  logic              WriteIn;
  logic [1:0]        SizeIn;
  logic              SignedIn;
  logic [31:0]       AddrIn;
  logic [31:0]       DataIn;
  logic              StallOut;
  logic              DoneOut;
  logic [31:0]       DataOut;
  logic              BusErrOut;
  logic              MisalignOut;
  logic              MemReqOut;
  logic              MemWeOut;
  logic [ADDR_W-1:0] MemAddrOut;
  logic [31:0]       MemWDataOut;
  logic [31:0]       MemRDataIn;
  logic              MemAckIn;

  modport master (
    input  ReqValidIn, ReadIn, WriteIn, SizeIn, SignedIn, AddrIn, DataIn,
    input  MemRDataIn, MemAckIn,
    output StallOut, DoneOut, DataOut, BusErrOut, MisalignOut,
    output MemReqOut, MemWeOut, MemAddrOut, MemWDataOut
  );

  modport slave (
    output ReqValidIn, ReadIn, WriteIn, SizeIn, SignedIn, AddrIn, DataIn,
    output MemRDataIn, MemAckIn,
    input  StallOut, DoneOut, DataOut, BusErrOut, MisalignOut,
    input  MemReqOut, MemWeOut, MemAddrOut, MemWDataOut
  );
endinterface

// File: rtl/mem_stage_master_lane_align.sv
// Combinational byte-lane logic: load extraction with zero/sign extension,
// and merge of store lanes into a read word for read-modify-write.
module lane_align import mem_pkg::*; (
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [31:0] shifted;
  logic [31:0] lanes;
  logic [3:0]  mask;

  always_comb begin
    shifted   = rdata >> {offset, 3'b000};
    load_data = shifted;
    lanes     = wdata;
    case (size)
      SZ_B: begin
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        lanes     = {4{wdata[7:0]}};
      end
      SZ_H: begin
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        lanes     = {2{wdata[15:0]}};
      end
      default: ;
    endcase
    mask   = lane_mask(size, offset);
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) merged[i*8 +: 8] = lanes[i*8 +: 8];
    end
  end
endmodule

// File: rtl/mem_stage_master.sv
// MEM-stage initiator: byte/half/word loads and stores onto a word memory with req/ack,
// RMW for sub-word stores, per-phase ack timeout. MISALIGN_TRAP_EN enables misaligned traps.
module mem_stage_master import mem_pkg::*; #(
  parameter int ADDR_W      = 5,
  parameter int ACK_TIMEOUT = 15
) (
  input logic                clkIn,
  input logic                resetIn,
  mem_stage_master_if.master bus
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        sz_q;
  logic [1:0]        off_q;
  logic              sgn_q;
  logic [31:0]       wd_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdat_q;
  logic              done_q;
  logic [31:0]       data_q;
  logic              berr_q;
  logic              mis_q;

  logic              accept;
  logic              phase;
  logic              timeout;
  logic              misaligned;
  logic [1:0]        sz_n;
  logic [1:0]        off_n;
  logic [31:0]       ld_data;
  logic [31:0]       mrg_data;
  logic              unused_addr;

  assign unused_addr = ^bus.AddrIn[31:ADDR_W+2];

  assign sz_n = (bus.SizeIn == 2'd3) ? SZ_W : bus.SizeIn;

  always_comb begin
    off_n = bus.AddrIn[1:0];
    if (sz_n == SZ_H)      off_n[0] = 1'b0;
    else if (sz_n == SZ_W) off_n    = 2'b00;
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((sz_n == SZ_H) && bus.AddrIn[0]) ||
                      ((sz_n == SZ_W) && (bus.AddrIn[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Accept is gated by reset so every output reads 0 while reset is held
  assign accept  = resetIn && (state == IDLE) && bus.ReqValidIn && (bus.ReadIn || bus.WriteIn);
  assign phase   = (state inside {RD, WR, RMW_RD, RMW_WR});
  assign timeout = (cnt == CW'(ACK_TIMEOUT - 1));

  lane_align u_lane_align (
    .size      (sz_q),
    .offset    (off_q),
    .sign_ext  (sgn_q),
    .rdata     (bus.MemRDataIn),
    .wdata     (wd_q),
    .load_data (ld_data),
    .merged    (mrg_data)
  );

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state  <= IDLE;
      cnt    <= '0;
      sz_q   <= SZ_B;
      off_q  <= 2'b00;
      sgn_q  <= 1'b0;
      wd_q   <= '0;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wdat_q <= '0;
      done_q <= 1'b0;
      data_q <= '0;
      berr_q <= 1'b0;
      mis_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      data_q <= '0;
      berr_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sz_q   <= sz_n;
            off_q  <= off_n;
            sgn_q  <= bus.SignedIn;
            wd_q   <= bus.DataIn;
            addr_q <= bus.AddrIn[ADDR_W+1:2];
            cnt    <= '0;
            if (misaligned) begin
              state  <= DONE;
              done_q <= 1'b1;
              mis_q  <= 1'b1;
            end else if (bus.WriteIn) begin
              req_q <= 1'b1;
              if (sz_n == SZ_W) begin
                state  <= WR;
                we_q   <= 1'b1;
                wdat_q <= bus.DataIn;
              end else begin
                state <= RMW_RD;
                we_q  <= 1'b0;
              end
            end else begin
              state <= RD;
              req_q <= 1'b1;
              we_q  <= 1'b0;
            end
          end
        end
        RD, WR, RMW_WR: begin
          if (bus.MemAckIn) begin
            state  <= DONE;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b1;
            if (state == RD) data_q <= ld_data;
          end else if (timeout) begin
            state  <= DONE;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b1;
            berr_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RMW_RD: begin
          // A timeout here abandons the store before any write is issued
          if (bus.MemAckIn) begin
            state  <= RMW_WR;
            we_q   <= 1'b1;
            wdat_q <= mrg_data;
            cnt    <= '0;
          end else if (timeout) begin
            state  <= DONE;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            done_q <= 1'b1;
            berr_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.StallOut    = accept || phase;
  assign bus.DoneOut     = done_q;
  assign bus.DataOut     = data_q;
  assign bus.BusErrOut   = berr_q;
  assign bus.MisalignOut = mis_q;
  assign bus.MemReqOut   = req_q;
  assign bus.MemWeOut    = we_q;
  assign bus.MemAddrOut  = addr_q;
  assign bus.MemWDataOut = wdat_q;
endmodule

// File: tb/tb_mem_stage_master.sv
// Randomised bench for mem_stage_master: a word-memory responder with programmable waits,
// a transaction-level expectation timeline, and literal checks for the documented scenarios.
module tb_mem_stage_master;
  localparam int ADDR_W = 5;
  localparam int T      = 15;
  localparam int MAXK   = 48;

  logic clkIn   = 1'b0;
  logic resetIn = 1'b0;
  always #5 clkIn = ~clkIn;

  mem_stage_master_if #(.ADDR_W(ADDR_W)) bus ();

  mem_stage_master #(.ADDR_W(ADDR_W), .ACK_TIMEOUT(T)) dut (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  int wait_ph [2];
  bit spurious = 1'b0;

  bit active = 1'b0;
  int cur_k  = 0;
  int txn_id = 0;
  bit e_stall [MAXK];
  bit e_req   [MAXK];
  bit e_we    [MAXK];
  bit e_done  [MAXK];
  logic [31:0] e_data;
  bit e_berr, e_mis;
  logic [4:0] e_idx;

  int stall_cnt;
  logic [31:0] last_data;
  bit last_berr, last_mis, saw_req;
  logic [4:0] last_addr;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (txn %0d cyc %0d): got %h expected %h", nm, txn_id, cur_k, act, exp);
    end
  endfunction

  // Compare process: checks outputs against the expected timeline each active cycle
  initial begin
    forever begin
      @(negedge clkIn);
      if (active) begin
        chk("stall",    {31'b0, bus.StallOut},    {31'b0, e_stall[cur_k]});
        chk("req",      {31'b0, bus.MemReqOut},   {31'b0, e_req[cur_k]});
        chk("done",     {31'b0, bus.DoneOut},     {31'b0, e_done[cur_k]});
        chk("data",     bus.DataOut,              e_done[cur_k] ? e_data : 32'h0);
        chk("buserr",   {31'b0, bus.BusErrOut},   {31'b0, e_done[cur_k] & e_berr});
        chk("misalign", {31'b0, bus.MisalignOut}, {31'b0, e_done[cur_k] & e_mis});
        if (e_req[cur_k]) begin
          chk("we",   {31'b0, bus.MemWeOut},  {31'b0, e_we[cur_k]});
          chk("addr", {27'b0, bus.MemAddrOut}, {27'b0, e_idx});
        end
        if (bus.MemReqOut) begin
          saw_req   = 1'b1;
          last_addr = bus.MemAddrOut;
        end
        if (bus.StallOut) stall_cnt++;
        if (bus.DoneOut) begin
          last_data = bus.DataOut;
          last_berr = bus.BusErrOut;
          last_mis  = bus.MisalignOut;
        end
      end
    end
  end

  // Memory responder: ack after wait_ph[phase] low cycles, write committed on the ack edge
  int wcnt = 0;
  int ph   = 0;
  bit pend = 1'b0;
  logic [4:0]  pa;
  logic [31:0] pd;
  initial begin
    bus.MemAckIn   = 1'b0;
    bus.MemRDataIn = 32'h0;
    forever begin
      @(negedge clkIn);
      if (bus.MemReqOut) begin
        if (wcnt >= wait_ph[ph]) begin
          bus.MemAckIn   = 1'b1;
          bus.MemRDataIn = mem[bus.MemAddrOut];
          if (bus.MemWeOut) begin
            pend = 1'b1;
            pa   = bus.MemAddrOut;
            pd   = bus.MemWDataOut;
          end
          wcnt = 0;
          ph   = 1;
        end else begin
          wcnt++;
          bus.MemAckIn   = 1'b0;
          bus.MemRDataIn = $urandom;
        end
      end else begin
        wcnt = 0;
        ph   = 0;
        bus.MemAckIn   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.MemRDataIn = $urandom;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clkIn);
      if (pend && resetIn) mem[pa] = pd;
      pend = 1'b0;
    end
  end

  task automatic run_txn(input bit v, input bit rd, input bit wr, input logic [1:0] sz,
                         input bit sg, input logic [31:0] addr, input logic [31:0] data,
                         input int w0, input int w1);
    int n, len0, len1;
    bit none, trap;
    logic [1:0] esz, off;
    logic [31:0] word, b, m;
    logic [4:0] idx;
    txn_id++;
    esz  = (sz == 2'd3) ? 2'd2 : sz;
    idx  = addr[6:2];
    off  = addr[1:0];
    none = !(v && (rd || wr));
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = !none && (((esz == 2'd1) && off[0]) || ((esz == 2'd2) && (off != 2'd0)));
`endif
    if (esz == 2'd1) off[0] = 1'b0;
    if (esz == 2'd2) off = 2'd0;
    for (int k = 0; k < MAXK; k++) begin
      e_stall[k] = 1'b0; e_req[k] = 1'b0; e_we[k] = 1'b0; e_done[k] = 1'b0;
    end
    e_data = 32'h0; e_berr = 1'b0; e_mis = 1'b0; e_idx = idx;
    word = ref_mem[idx];
    n = 0;
    if (!none && trap) begin
      n = 1; e_mis = 1'b1; e_stall[0] = 1'b1; e_done[1] = 1'b1;
    end else if (!none) begin
      len0 = (w0 < T) ? w0 + 1 : T;
      for (int k = 1; k <= len0; k++) begin
        e_stall[k] = 1'b1; e_req[k] = 1'b1; e_we[k] = wr && (esz == 2'd2);
      end
      n = 1 + len0;
      if (w0 >= T) begin
        e_berr = 1'b1;
      end else if (!wr) begin
        if (esz == 2'd0) begin
          b = (word >> (8 * off)) & 32'hFF;
          if (sg && b[7]) b = b | 32'hFFFF_FF00;
        end else if (esz == 2'd1) begin
          b = (word >> (8 * off)) & 32'hFFFF;
          if (sg && b[15]) b = b | 32'hFFFF_0000;
        end else begin
          b = word;
        end
        e_data = b;
      end else if (esz == 2'd2) begin
        ref_mem[idx] = data;
      end else begin
        len1 = (w1 < T) ? w1 + 1 : T;
        for (int k = n; k < n + len1; k++) begin
          e_stall[k] = 1'b1; e_req[k] = 1'b1; e_we[k] = 1'b1;
        end
        n = n + len1;
        if (w1 >= T) begin
          e_berr = 1'b1;
        end else begin
          m = (esz == 2'd0) ? 32'hFF : 32'hFFFF;
          ref_mem[idx] = (word & ~(m << (8 * off))) | ((data & m) << (8 * off));
        end
      end
      e_stall[0] = 1'b1;
      e_done[n]  = 1'b1;
    end
    wait_ph[0] = w0; wait_ph[1] = w1;
    stall_cnt = 0; saw_req = 1'b0; last_data = 32'h5A5A5A5A; last_berr = 1'b0; last_mis = 1'b0;
    last_addr = 5'h1F;
    bus.ReqValidIn = v; bus.ReadIn = rd; bus.WriteIn = wr; bus.SizeIn = sz;
    bus.SignedIn = sg; bus.AddrIn = addr; bus.DataIn = data;
    active = 1'b1;
    for (int k = 0; k <= n + 1; k++) begin
      cur_k = k;
      if (k == n + 1) bus.ReqValidIn = 1'b0;
      @(posedge clkIn); #1;
    end
    active = 1'b0;
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    if (r == 7) return T - 1;
    if (r == 8) return T;
    return T + 2;
  endfunction

  initial begin
    bus.ReqValidIn = 1'b1; bus.ReadIn = 1'b1; bus.WriteIn = 1'b0; bus.SizeIn = 2'd2;
    bus.SignedIn = 1'b0; bus.AddrIn = 32'h0; bus.DataIn = 32'h0;
    wait_ph[0] = 0; wait_ph[1] = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clkIn);
    #1;
    chk("rst_stall", {31'b0, bus.StallOut},    32'h0);
    chk("rst_done",  {31'b0, bus.DoneOut},     32'h0);
    chk("rst_data",  bus.DataOut,              32'h0);
    chk("rst_berr",  {31'b0, bus.BusErrOut},   32'h0);
    chk("rst_mis",   {31'b0, bus.MisalignOut}, 32'h0);
    chk("rst_req",   {31'b0, bus.MemReqOut},   32'h0);
    chk("rst_we",    {31'b0, bus.MemWeOut},    32'h0);
    chk("rst_addr",  {27'b0, bus.MemAddrOut},  32'h0);
    chk("rst_wdata", bus.MemWDataOut,          32'h0);
    bus.ReqValidIn = 1'b0;
    @(negedge clkIn); resetIn = 1'b1;
    @(posedge clkIn); #1;

    mem[4] = 32'hDEADBEEF; ref_mem[4] = mem[4];
    run_txn(1, 1, 0, 2'd2, 0, 32'h10, 32'h0, 0, 0);
    chk("tp_word_load_stall", stall_cnt, 2);
    chk("tp_word_load_data", last_data, 32'hDEADBEEF);

    mem[4] = 32'h80FF_0000; ref_mem[4] = mem[4];
    run_txn(1, 1, 0, 2'd0, 1, 32'h13, 32'h0, 0, 0);
    chk("tp_sbyte_load", last_data, 32'hFFFFFF80);
    run_txn(1, 1, 0, 2'd0, 0, 32'h13, 32'h0, 1, 0);
    chk("tp_ubyte_load", last_data, 32'h00000080);

    mem[2] = 32'hAAAABBBB; ref_mem[2] = mem[2];
    run_txn(1, 0, 1, 2'd1, 0, 32'h0A, 32'h0000_1234, 0, 0);
    chk("tp_half_store_stall", stall_cnt, 3);
    chk("tp_half_store_mem", mem[2], 32'h1234BBBB);

    run_txn(1, 1, 0, 2'd2, 0, 32'h20, 32'h0, T + 3, 0);
    chk("tp_timeout_berr", {31'b0, last_berr}, 32'h1);
    chk("tp_timeout_data", last_data, 32'h0);
    chk("tp_timeout_stall", stall_cnt, T + 1);
    run_txn(1, 1, 0, 2'd2, 0, 32'h24, 32'h0, T - 1, 0);
    chk("tp_last_wait_berr", {31'b0, last_berr}, 32'h0);
    run_txn(1, 0, 1, 2'd0, 0, 32'h31, 32'h77, 0, T);

    mem[1] = 32'h0BADF00D; ref_mem[1] = mem[1];
    run_txn(1, 1, 0, 2'd2, 0, 32'h06, 32'h0, 0, 0);
`ifdef MISALIGN_TRAP_EN
    chk("tp_mis_flag", {31'b0, last_mis}, 32'h1);
    chk("tp_mis_noreq", {31'b0, saw_req}, 32'h0);
    chk("tp_mis_stall", stall_cnt, 1);
`else
    chk("tp_align_addr", {27'b0, last_addr}, 32'h1);
    chk("tp_align_data", last_data, 32'h0BADF00D);
`endif

    run_txn(1, 1, 1, 2'd3, 0, 32'h40, 32'hCAFEF00D, 0, 0);
    run_txn(1, 0, 0, 2'd2, 0, 32'h44, 32'h0, 0, 0);

    // Reset while the RMW write phase is waiting for ack
    mem[9] = 32'h11223344; ref_mem[9] = mem[9];
    wait_ph[0] = 0; wait_ph[1] = 2;
    bus.ReqValidIn = 1'b1; bus.ReadIn = 1'b0; bus.WriteIn = 1'b1; bus.SizeIn = 2'd0;
    bus.SignedIn = 1'b0; bus.AddrIn = 32'h25; bus.DataIn = 32'hEE;
    repeat (3) begin @(posedge clkIn); #1; end
    chk("rst_mid_req_before", {31'b0, bus.MemReqOut}, 32'h1);
    chk("rst_mid_we_before",  {31'b0, bus.MemWeOut},  32'h1);
    resetIn = 1'b0;
    #1;
    chk("rst_mid_req",   {31'b0, bus.MemReqOut}, 32'h0);
    chk("rst_mid_stall", {31'b0, bus.StallOut},  32'h0);
    chk("rst_mid_done",  {31'b0, bus.DoneOut},   32'h0);
    chk("rst_mid_data",  bus.DataOut,            32'h0);
    chk("rst_mid_we",    {31'b0, bus.MemWeOut},  32'h0);
    bus.ReqValidIn = 1'b0;
    repeat (3) @(posedge clkIn);
    @(negedge clkIn); resetIn = 1'b1;
    @(posedge clkIn); #1;
    chk("rst_mid_mem", mem[9], 32'h11223344);
    run_txn(1, 1, 0, 2'd2, 0, 32'h24, 32'h0, 0, 0);
    chk("rst_mid_reload", last_data, 32'h11223344);

    spurious = 1'b1;
    for (int i = 0; i < 200; i++) begin
      run_txn(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom,
              pick_wait(), pick_wait());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
